// File: rtl/sonar_pkg.sv
// Shared definitions for the ultrasonic ranging emulator and its controller:
// FSM state encodings, counter widths and default timing constants.
package sonar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRIG  = 3'd1,
      ST_BURST = 3'd2,
      ST_ECHO  = 3'd3,
      ST_HOLD  = 3'd4
   } sonar_state_e;

   localparam int unsigned CNT_W  = 21;
   localparam int unsigned DIST_W = 9;

   // Defaults assume a 50 MHz sys_clk
   localparam int unsigned TRIG_MIN_CYC_DEF = 500;
   localparam int unsigned BURST_CYC_DEF    = 10000;
   localparam int unsigned CYC_PER_CM_DEF   = 2900;
   localparam int unsigned MAX_CM_DEF       = 400;
   localparam int unsigned TIMEOUT_CYC_DEF  = 1900000;
   localparam int unsigned HOLDOFF_CYC_DEF  = 50000;

   // Echo width in clocks; zero or out-of-range distances report a timeout.
   function automatic logic [CNT_W-1:0] echo_width(
      input logic [DIST_W-1:0] cm,
      input int unsigned       cyc_per_cm,
      input int unsigned       max_cm,
      input int unsigned       timeout_cyc
   );
      logic [CNT_W-1:0] prod;
      prod = CNT_W'(cm) * CNT_W'(cyc_per_cm);
      if (cm == '0 || 32'(cm) > max_cm) begin
         return CNT_W'(timeout_cyc);
      end
      return prod;
   endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a history flop that
// yields single-clock rise/fall strobes alongside the synchronized level.
module sig_sync_edge (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;
   assign fall  = ~sync & prev;

endmodule

// File: rtl/echo_responder.sv
// Emulates an ultrasonic ranging sensor: validates a trigger pulse, waits the
// burst time, then returns an echo whose width encodes the switch distance.
//
// state | meaning
// IDLE  | waiting for a fresh trigger rise
// TRIG  | trigger high, measuring its width
// BURST | fixed delay between trigger fall and echo rise
// ECHO  | echo_vld high for the distance-derived width
// HOLD  | dead time after echo, triggers ignored
module echo_responder
   import sonar_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
   parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
   parameter int unsigned CYC_PER_CM   = CYC_PER_CM_DEF,
   parameter int unsigned MAX_CM       = MAX_CM_DEF,
   parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
   parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              trig_vld,
   input  logic [DIST_W-1:0] distance_cm,
   output logic              echo_vld,
   output logic              busy,
   output logic              trig_err
);

   localparam int unsigned       WCNT_W   = $clog2(TRIG_MIN_CYC + 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TRIG_MIN_CYC);

   logic trig_level;
   logic trig_rise;
   logic trig_fall;

   sonar_state_e      state;
   logic [CNT_W-1:0]  tmr;
   logic [WCNT_W-1:0] wcnt;
   logic [DIST_W-1:0] cm_lat;
   logic [1:0]        settle;
   logic              armed;

   sig_sync_edge u_trig_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .async_in  (trig_vld),
      .level     (trig_level),
      .rise      (trig_rise),
      .fall      (trig_fall)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         tmr      <= '0;
         wcnt     <= '0;
         cm_lat   <= '0;
         settle   <= '0;
         armed    <= 1'b0;
         echo_vld <= 1'b0;
         busy     <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         trig_err <= 1'b0;
         // The synchronizer leaves reset at 0, so a trigger held high across
         // release looks like a rise; only arm once a real low has been seen.
         settle   <= {settle[0], 1'b1};
         if (settle[1] && !trig_level) begin
            armed <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (trig_rise && armed) begin
                  wcnt  <= '0;
                  busy  <= 1'b1;
                  state <= ST_TRIG;
               end
            end
            ST_TRIG: begin
               if (trig_fall) begin
                  if (wcnt >= WCNT_MAX) begin
                     cm_lat <= distance_cm;
                     tmr    <= CNT_W'(BURST_CYC);
                     state  <= ST_BURST;
                  end else begin
                     trig_err <= 1'b1;
                     busy     <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end else if (wcnt != WCNT_MAX) begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            ST_BURST: begin
               // Latch clock plus BURST_CYC counted clocks; echo_vld is set on
               // the transition so the rise lands with the echo register.
               if (tmr == '0) begin
                  tmr      <= echo_width(cm_lat, CYC_PER_CM, MAX_CM, TIMEOUT_CYC) - 1'b1;
                  echo_vld <= 1'b1;
                  state    <= ST_ECHO;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_ECHO: begin
               if (tmr == '0) begin
                  echo_vld <= 1'b0;
                  tmr      <= CNT_W'(HOLDOFF_CYC - 1);
                  state    <= ST_HOLD;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_HOLD: begin
               if (tmr == '0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: begin
               echo_vld <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_echo_responder.sv
// Directed scoreboard bench for echo_responder with shortened timing constants.
module tb_echo_responder;

   localparam int TMIN  = 4;
   localparam int BURST = 8;
   localparam int CPC   = 3;
   localparam int MAXCM = 400;
   localparam int TO    = 1500;
   localparam int HOLD  = 16;

   logic       sys_clk     = 1'b0;
   logic       sys_rst_n   = 1'b0;
   logic       trig_vld    = 1'b0;
   logic [8:0] distance_cm = '0;
   logic       echo_vld;
   logic       busy;
   logic       trig_err;

   echo_responder #(
      .TRIG_MIN_CYC (TMIN),
      .BURST_CYC    (BURST),
      .CYC_PER_CM   (CPC),
      .MAX_CM       (MAXCM),
      .TIMEOUT_CYC  (TO),
      .HOLDOFF_CYC  (HOLD)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .trig_vld    (trig_vld),
      .distance_cm (distance_cm),
      .echo_vld    (echo_vld),
      .busy        (busy),
      .trig_err    (trig_err)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      int rise;
      int width;
   } exp_t;

   exp_t sb[$];
   int   n_cmp      = 0;
   int   n_bad      = 0;
   int   err_pulses = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Monitor: measures each echo pulse and compares against the scoreboard
   logic echo_q = 1'b0;
   logic err_q  = 1'b0;
   int   rise_c = 0;
   int   w      = 0;

   always @(negedge sys_clk) begin
      if (echo_vld && !echo_q) begin
         rise_c = cyc;
         w      = 1;
      end else if (echo_vld) begin
         w++;
      end
      if (!echo_vld && echo_q) begin
         if (sb.size() == 0) begin
            check("unexpected_echo", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("echo_rise_cyc", rise_c, e.rise);
            check("echo_width", w, e.width);
         end
      end
      if (trig_err) begin
         err_pulses++;
         if (err_q) check("trig_err_len", 2, 1);
      end
      echo_q = echo_vld;
      err_q  = trig_err;
   end

   // Echo rises 12 clocks after the negedge that drops the trigger
   task automatic pulse(input int hi, input logic [8:0] cm, input int exp_w);
      @(negedge sys_clk);
      distance_cm = cm;
      trig_vld    = 1'b1;
      repeat (hi) @(negedge sys_clk);
      trig_vld = 1'b0;
      if (exp_w > 0) sb.push_back('{rise: cyc + 12, width: exp_w});
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      repeat (4) @(negedge sys_clk);
      while (busy && n < 6000) begin
         @(negedge sys_clk);
         n++;
      end
      check({name, "_idle_timeout"}, int'(busy), 0);
      check({name, "_echo_pending"}, sb.size(), 0);
   endtask

   task automatic wait_echo(input logic lvl, input string name);
      int n;
      n = 0;
      while (echo_vld !== lvl && n < 5000) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, int'(echo_vld), int'(lvl));
   endtask

   initial begin
      int t0;

      repeat (5) @(negedge sys_clk);
      check("rst_echo_vld", int'(echo_vld), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_trig_err", int'(trig_err), 0);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      // Nominal measurement
      pulse(10, 9'd100, 300);
      wait_idle("nominal");

      // Short triggers
      pulse(2, 9'd100, -1);
      wait_idle("short2");
      check("err_count_1", err_pulses, 1);
      pulse(3, 9'd100, -1);
      wait_idle("short3");
      check("err_count_2", err_pulses, 2);

      // Range boundaries
      pulse(10, 9'd0, TO);
      wait_idle("cm0");
      pulse(10, 9'd401, TO);
      wait_idle("cm401");
      pulse(10, 9'd400, 1200);
      wait_idle("cm400");
      pulse(10, 9'd1, 3);
      wait_idle("cm1");

      // Triggers during ECHO and HOLD are dropped
      pulse(10, 9'd10, 30);
      wait_echo(1'b1, "echo_rise_seen");
      pulse(6, 9'd77, -1);
      wait_echo(1'b0, "echo_fall_seen");
      @(negedge sys_clk);
      pulse(5, 9'd77, -1);
      wait_idle("ignored");
      pulse(10, 9'd20, 60);
      wait_idle("after_hold");

      // Distance change after latch
      pulse(10, 9'd50, 150);
      repeat (5) @(negedge sys_clk);
      distance_cm = 9'd200;
      wait_idle("cm_change");

      // Reset mid-echo with trigger held across release
      pulse(10, 9'd100, 21);
      t0 = cyc;
      while (cyc < t0 + 32) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      trig_vld  = 1'b1;
      @(negedge sys_clk);
      check("echo_after_rst", int'(echo_vld), 0);
      check("busy_after_rst", int'(busy), 0);
      sys_rst_n = 1'b1;
      repeat (40) @(negedge sys_clk);
      check("held_trig_busy", int'(busy), 0);
      trig_vld = 1'b0;
      repeat (5) @(negedge sys_clk);
      check("held_trig_no_echo_busy", int'(busy), 0);
      pulse(10, 9'd30, 90);
      wait_idle("post_rst");

      repeat (20) @(negedge sys_clk);
      check("final_err_count", err_pulses, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
